// File: rtl/word_serializer_pkg.sv
// +--------------------------------------------------------------------+
// | word_serializer_pkg : state encoding and counter sizing helper     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package word_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit-index counter must hold 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_register.sv
// +--------------------------------------------------------------------+
// | piso_shift_register : parallel load, serial shift, registered out  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module piso_shift_register #(
  parameter int WIDTH      = 32,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             park,
  input  logic [WIDTH-1:0] data,
  output logic             serial
);

  logic [WIDTH-1:0] shreg;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // The serial register always shows the bit currently on the line, so the
  // first bit is taken straight from the load data rather than the shifter.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign first_bit = data[WIDTH-1];
      assign next_bit  = shreg[WIDTH-2];
      assign shifted   = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign first_bit = data[0];
      assign next_bit  = shreg[1];
      assign shifted   = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      serial <= 1'(IDLE_LEVEL);
    end else if (load) begin
      shreg  <= data;
      serial <= first_bit;
    end else if (shift_en) begin
      shreg  <= shifted;
      serial <= next_bit;
    end else if (park) begin
      serial <= 1'(IDLE_LEVEL);
    end
  end

endmodule

`default_nettype wire

// File: rtl/word_serializer.sv
// +--------------------------------------------------------------------+
// | word_serializer : valid/ready word in, framed serial bitstream out |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input  logic             In_Clock,
  input  logic             In_Reset,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             Out_Ready,
  input  logic             In_Tick,
  output logic             Out_Serial,
  output logic             Out_Frame,
  output logic             Out_Done
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          last_tick;
  logic          accept;
  logic          shift_en;
  logic          park;

  assign last_tick = (state == ST_SHIFT) && In_Tick && (count == LAST);
  assign Out_Ready = (state == ST_IDLE) || (state == ST_DONE) || last_tick;
  assign accept    = In_Valid && Out_Ready;
  assign shift_en  = (state == ST_SHIFT) && In_Tick && (count != LAST);
  assign park      = last_tick && !accept;

  always_ff @(posedge In_Clock) begin
    if (In_Reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      Out_Frame <= 1'b0;
      Out_Done  <= 1'b0;
    end else begin
      Out_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SHIFT;
            count     <= '0;
            Out_Frame <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (In_Tick) begin
            if (count != LAST) begin
              count <= count + CW'(1);
            end else begin
              // Done pulses on both exits; a reload keeps the frame unbroken.
              Out_Done <= 1'b1;
              count    <= '0;
              if (!accept) begin
                state     <= ST_DONE;
                Out_Frame <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          if (accept) begin
            state     <= ST_SHIFT;
            count     <= '0;
            Out_Frame <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          count     <= '0;
          Out_Frame <= 1'b0;
        end
      endcase
    end
  end

  piso_shift_register #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_piso (
    .clk      (In_Clock),
    .rst      (In_Reset),
    .load     (accept),
    .shift_en (shift_en),
    .park     (park),
    .data     (In_Data),
    .serial   (Out_Serial)
  );

endmodule

`default_nettype wire
